// File: rtl/isp_yuv422_axis_pkg.sv
// ---------------------------------------------------------------------------
// isp_yuv422_axis_pkg : shared codes for the YUV422 AXI4-Stream output stage
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package isp_yuv422_axis_pkg;

  typedef enum logic [1:0] {
    BAYER_RGGB = 2'd0,
    BAYER_GRBG = 2'd1,
    BAYER_GBRG = 2'd2,
    BAYER_BGGR = 2'd3
  } bayer_t;

  // YUYV beat order within one pixel pair
  localparam logic BEAT_U = 1'b0;
  localparam logic BEAT_V = 1'b1;

  typedef enum logic [0:0] {
    BEAT0 = BEAT_U,
    BEAT1 = BEAT_V
  } beat_state_t;

endpackage

`default_nettype wire

// File: rtl/vid_fifo_sync.sv
// ---------------------------------------------------------------------------
// vid_fifo_sync : single-clock FIFO with registered-read RAM and level output
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module vid_fifo_sync #(
  parameter int DW = 34,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_rd_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  localparam int          c_DEPTH = 2**AW;
  localparam logic [AW:0] c_FULL  = (AW+1)'(c_DEPTH);

  logic [DW-1:0] r_mem [c_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [DW-1:0] r_rd_data;
  logic          w_wr;
  logic          w_rd;

  assign o_full    = (r_level == c_FULL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_rd_data;
  assign w_wr      = i_wr_en & ~o_full;
  assign w_rd      = i_rd_en & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/isp_yuv422_axis.sv
// ---------------------------------------------------------------------------
// isp_yuv422_axis : YUV444 -> YUYV 4:2:2 packer with FIFO and AXI4-Stream out
// Option macro YUV422_CHROMA_AVG_EN: average chroma of each pixel pair.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module isp_yuv422_axis
  import isp_yuv422_axis_pkg::*;
#(
  parameter int BITS    = 8,
  parameter int WIDTH   = 1280,
  parameter int FIFO_AW = 9
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              in_href,
  input  logic              in_vsync,
  input  logic [BITS-1:0]   in_y,
  input  logic [BITS-1:0]   in_u,
  input  logic [BITS-1:0]   in_v,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [2*BITS-1:0] m_axis_tdata,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  input  logic              ovf_clr,
  output logic              ovf_err,
  output logic              len_err,
  output logic [FIFO_AW:0]  fifo_level
);

  localparam int             c_EW     = 4*BITS + 2;
  localparam int             c_XW     = $clog2(WIDTH + 1);
  localparam logic [c_XW-1:0] c_X_LAST = c_XW'(WIDTH - 1);
  localparam logic [c_XW-1:0] c_X_END  = c_XW'(WIDTH);

  logic            r_href_q, r_href_d, r_vs_q, r_vs_d;
  logic [BITS-1:0] r_y_q, r_u_q, r_v_q;
  logic [BITS-1:0] r_y0, r_u0, r_v0;
  logic [c_XW-1:0] r_x;
  logic            r_sof, r_wait, r_ovf_err, r_len_err;
  logic            r_tvalid;
  beat_state_t     r_beat;

  logic            w_vs_rise, w_href_fall, w_pix, w_in_range, w_pair;
  logic            w_push, w_ovf_set, w_len_set;
  logic [BITS-1:0] w_u, w_v;
  logic [c_EW-1:0] w_wr_data, w_entry;
  logic            w_full, w_empty, w_last_acc, w_pop;

  // vsync pipeline resets high so a frame already in progress is not seen as a new one
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_href_q <= 1'b0;
      r_href_d <= 1'b0;
      r_vs_q   <= 1'b1;
      r_vs_d   <= 1'b1;
      r_y_q    <= '0;
      r_u_q    <= '0;
      r_v_q    <= '0;
    end else begin
      r_href_q <= in_href;
      r_href_d <= r_href_q;
      r_vs_q   <= in_vsync;
      r_vs_d   <= r_vs_q;
      r_y_q    <= in_y;
      r_u_q    <= in_u;
      r_v_q    <= in_v;
    end
  end

  assign w_vs_rise   = r_vs_q & ~r_vs_d;
  assign w_href_fall = r_href_d & ~r_href_q;
  assign w_pix       = r_href_q & ~r_wait & ~w_vs_rise;
  assign w_in_range  = (r_x < c_X_END);
  assign w_pair      = w_pix & w_in_range & r_x[0];
  assign w_push      = w_pair & ~w_full;
  assign w_ovf_set   = w_pair & w_full;
  assign w_len_set   = (w_pix & ~w_in_range) |
                       (w_href_fall & ~r_wait & ~w_vs_rise & (r_x != c_X_END));

`ifdef YUV422_CHROMA_AVG_EN
  logic [BITS:0] w_u_sum, w_v_sum;
  assign w_u_sum = {1'b0, r_u0} + {1'b0, r_u_q} + (BITS+1)'(1);
  assign w_v_sum = {1'b0, r_v0} + {1'b0, r_v_q} + (BITS+1)'(1);
  assign w_u     = w_u_sum[BITS:1];
  assign w_v     = w_v_sum[BITS:1];
`else
  assign w_u = r_u0;
  assign w_v = r_v0;
`endif

  assign w_wr_data = {r_sof, (r_x == c_X_LAST), r_y0, r_y_q, w_u, w_v};

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_sof  <= 1'b0;
      r_wait <= 1'b1;
      r_y0   <= '0;
      r_u0   <= '0;
      r_v0   <= '0;
    end else if (w_vs_rise) begin
      r_x    <= '0;
      r_sof  <= 1'b1;
      r_wait <= 1'b0;
    end else if (!r_wait) begin
      if (w_href_fall) begin
        r_x <= '0;
      end else if (r_href_q && w_in_range) begin
        r_x <= r_x + c_XW'(1);
        if (!r_x[0]) begin
          r_y0 <= r_y_q;
          r_u0 <= r_u_q;
          r_v0 <= r_v_q;
        end
        if (w_push) r_sof <= 1'b0;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_err <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_ovf_err <= w_ovf_set | (r_ovf_err & ~ovf_clr);
      r_len_err <= w_len_set | (r_len_err & ~ovf_clr);
    end
  end

  vid_fifo_sync #(
    .DW (c_EW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (pclk),
    .rst_n     (rst_n),
    .i_wr_en   (w_push),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_entry),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (fifo_level)
  );

  // The FIFO read register holds the current pair; it only advances on a pop
  assign w_last_acc = r_tvalid & m_axis_tready & (r_beat == BEAT1);
  assign w_pop      = ~w_empty & (~r_tvalid | w_last_acc);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_tvalid <= 1'b0;
      r_beat   <= BEAT0;
    end else if (w_pop) begin
      r_tvalid <= 1'b1;
      r_beat   <= BEAT0;
    end else if (r_tvalid && m_axis_tready) begin
      if (r_beat == BEAT0) begin
        r_beat <= BEAT1;
      end else begin
        r_tvalid <= 1'b0;
        r_beat   <= BEAT0;
      end
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = (r_beat == BEAT1) ? {w_entry[BITS-1:0], w_entry[3*BITS-1:2*BITS]}
                                           : {w_entry[2*BITS-1:BITS], w_entry[4*BITS-1:3*BITS]};
  assign m_axis_tuser  = r_tvalid & (r_beat == BEAT0) & w_entry[c_EW-1];
  assign m_axis_tlast  = r_tvalid & (r_beat == BEAT1) & w_entry[c_EW-2];
  assign ovf_err       = r_ovf_err;
  assign len_err       = r_len_err;

endmodule

`default_nettype wire

// File: tb/tb_isp_yuv422_axis.sv
// ---------------------------------------------------------------------------
// tb_isp_yuv422_axis : directed bench for isp_yuv422_axis (WIDTH=8, FIFO_AW=4)
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_isp_yuv422_axis;

  localparam int BITS    = 8;
  localparam int WIDTH   = 8;
  localparam int FIFO_AW = 4;

  logic              pclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_href = 1'b0;
  logic              in_vsync = 1'b0;
  logic [BITS-1:0]   in_y = '0, in_u = '0, in_v = '0;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic [2*BITS-1:0] m_axis_tdata;
  logic              m_axis_tuser, m_axis_tlast;
  logic              ovf_clr = 1'b0;
  logic              ovf_err, len_err;
  logic [FIFO_AW:0]  fifo_level;

  isp_yuv422_axis #(.BITS(BITS), .WIDTH(WIDTH), .FIFO_AW(FIFO_AW)) dut (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .in_href       (in_href),
    .in_vsync      (in_vsync),
    .in_y          (in_y),
    .in_u          (in_u),
    .in_v          (in_v),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .ovf_clr       (ovf_clr),
    .ovf_err       (ovf_err),
    .len_err       (len_err),
    .fifo_level    (fifo_level)
  );

  always #5 pclk = ~pclk;

  int          n_chk = 0, n_fail = 0, cyc = 0;
  int          n_beats = 0, n_pushed = 0;
  int          t_odd = -1, t_first = -1;
  int          exp_budget = -1;
  bit          exp_en = 1'b1, exp_sof = 1'b0, rnd_done = 1'b0;
  bit          prev_stall = 1'b0;
  logic [18:0] prev_out = '0;
  logic [17:0] exp_q[$];

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, prev_out);
      if (m_axis_tvalid && t_first < 0) t_first = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        n_beats++;
        if (exp_q.size() == 0) chk("extra_beat", n_beats, n_pushed);
        else chk("beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
      end
      prev_stall = m_axis_tvalid & ~m_axis_tready;
      prev_out   = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic step();
    @(posedge pclk); #1;
  endtask

  // Y = line*16 + x, U = 0x10 + x, V = 0x80 + x
  task automatic pix(input int x, input int line);
    logic [7:0] y0, y1, u, v;
    in_href = 1'b1;
    in_y = 8'(line*16 + x);
    in_u = 8'(8'h10 + x);
    in_v = 8'(8'h80 + x);
    if (x == 1 && t_odd < 0) t_odd = cyc;
    if (x % 2 == 1 && x < WIDTH && exp_en && exp_budget != 0) begin
      y0 = 8'(line*16 + x - 1);
      y1 = 8'(line*16 + x);
`ifdef YUV422_CHROMA_AVG_EN
      u = 8'(8'h10 + x);
      v = 8'(8'h80 + x);
`else
      u = 8'(8'h10 + x - 1);
      v = 8'(8'h80 + x - 1);
`endif
      exp_q.push_back({exp_sof, 1'b0, u, y0});
      exp_q.push_back({1'b0, (x == WIDTH-1), v, y1});
      n_pushed += 2;
      exp_sof = 1'b0;
      if (exp_budget > 0) exp_budget--;
    end
    step();
  endtask

  task automatic send_line(input int n, input int line);
    for (int x = 0; x < n; x++) pix(x, line);
    in_href = 1'b0;
    repeat (6) step();
  endtask

  task automatic frame_start();
    in_vsync = 1'b0;
    repeat (3) step();
    in_vsync = 1'b1;
    exp_sof  = 1'b1;
    repeat (3) step();
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || fifo_level != 0 || m_axis_tvalid) && k < 400) begin
      step();
      k++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic clr_pulse();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    step();
  endtask

  initial begin
    int nb;
    repeat (3) step();
    chk("reset_outs", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata,
                       ovf_err, len_err, fifo_level}, 0);
    rst_n = 1'b1;
    repeat (3) step();

    // 1: single line, latency, no errors
    frame_start();
    send_line(8, 0);
    drain("t1_drain");
    chk("t1_latency", t_first - t_odd, 3);
    chk("t1_errs", {ovf_err, len_err}, 0);

    // 2: two 4-line frames
    for (int f = 0; f < 2; f++) begin
      frame_start();
      for (int l = 0; l < 4; l++) send_line(8, l);
    end
    drain("t2_drain");
    chk("t2_level", fifo_level, 0);

    // 3: long stall -> 1 pair in output register + 16 in FIFO, rest dropped
    m_axis_tready = 1'b0;
    exp_budget    = 17;
    frame_start();
    for (int l = 0; l < 6; l++) send_line(8, l);
    exp_budget = -1;
    repeat (1900) step();
    chk("t3_level", fifo_level, 16);
    chk("t3_ovf", ovf_err, 1);
    chk("t3_tvalid", m_axis_tvalid, 1);
    m_axis_tready = 1'b1;
    drain("t3_drain");
    frame_start();
    send_line(8, 0);
    drain("t3_next_frame");
    clr_pulse();
    chk("t3_ovf_clr", ovf_err, 0);

    // 4: short line then long line
    frame_start();
    send_line(7, 0);
    send_line(10, 1);
    drain("t4_drain");
    chk("t4_len", len_err, 1);
    clr_pulse();
    chk("t4_len_clr", len_err, 0);

    // 5: random backpressure over a full frame
    nb = n_beats;
    fork
      begin
        frame_start();
        for (int l = 0; l < 4; l++) send_line(8, l);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          m_axis_tready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    m_axis_tready = 1'b1;
    drain("t5_drain");
    chk("t5_beats", n_beats - nb, 32);
    chk("t5_level", fifo_level, 0);
    chk("t5_errs", {ovf_err, len_err}, 0);

    // 6: reset mid-line
    frame_start();
    for (int x = 0; x < 5; x++) pix(x, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_async", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata,
                         ovf_err, len_err, fifo_level}, 0);
    exp_q.delete();
    n_pushed = n_beats;
    exp_en   = 1'b0;
    repeat (3) @(posedge pclk);
    #3 rst_n = 1'b1;
    step();
    nb = n_beats;
    for (int x = 5; x < 8; x++) pix(x, 0);
    in_href = 1'b0;
    repeat (6) step();
    send_line(8, 1);
    repeat (20) step();
    chk("t6_quiet", n_beats - nb, 0);
    exp_en = 1'b1;
    frame_start();
    send_line(8, 2);
    drain("t6_drain");
    chk("t6_beats", n_beats - nb, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
